// File: rtl/linear_router.sv
// linear_router: three-port wormhole router node (local/west/east) for a linear chain.
// Define LINEAR_ROUTER_STATS_EN to add per-output saturating flit counters (flit_count).
//
// state  | meaning
// IDLE   | output free; head/single flits from any input may be granted round-robin
// LOCKED | output owned by one input until its tail (or single) flit transfers out
module linear_router #(
    parameter int N          = 4,
    parameter int INDEX      = 0,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int DEST_WIDTH = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3*DATA_WIDTH-1:0] data_in_bus,
    input  logic [2:0]              valid_in_bus,
    output logic [2:0]              ready_in_bus,
    output logic [3*DATA_WIDTH-1:0] data_out_bus,
    output logic [2:0]              valid_out_bus,
`ifdef LINEAR_ROUTER_STATS_EN
    output logic [3*32-1:0]         flit_count,
`endif
    input  logic [2:0]              ready_out_bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    logic [DATA_WIDTH-1:0] mem [3][FIFO_DEPTH];
    logic [AW:0]           wr_ptr [3];
    logic [AW:0]           rd_ptr [3];
    logic [2:0]            full, empty, push, pop;
    logic [DATA_WIDTH-1:0] head_flit [3];
    logic [1:0]            route [3];
    logic                  ready_en;

    state_t     state_q [3];
    state_t     state_d [3];
    logic [1:0] src_q [3];
    logic [1:0] src_d [3];
    logic [1:0] rr_q [3];
    logic [1:0] rr_d [3];
    logic [1:0] sel [3];
    logic [1:0] gnt [3];
    logic [2:0] req [3];
    logic [2:0] hit, active, xfer;

    // Out-of-range destinations and edge-of-chain overruns are delivered locally.
    function automatic logic [1:0] route_of(input logic [DEST_WIDTH-1:0] dest);
        if (int'(dest) >= N || int'(dest) == INDEX) return 2'd0;
        else if (int'(dest) < INDEX) return (INDEX == 0) ? 2'd0 : 2'd1;
        else return (INDEX == N - 1) ? 2'd0 : 2'd2;
    endfunction

    function automatic logic [1:0] wrap3(input logic [1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= 3) sum = sum - 3;
        return sum[1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en <= 1'b0;
            for (int p = 0; p < 3; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
            end
        end else begin
            ready_en <= 1'b1;
            for (int p = 0; p < 3; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (push[p]) mem[p][wr_ptr[p][AW-1:0]] <= data_in_bus[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        full         = '0;
        empty        = '0;
        ready_in_bus = '0;
        push         = '0;
        for (int p = 0; p < 3; p++) begin
            empty[p]        = (wr_ptr[p] == rd_ptr[p]);
            full[p]         = (wr_ptr[p][AW] != rd_ptr[p][AW]) &&
                              (wr_ptr[p][AW-1:0] == rd_ptr[p][AW-1:0]);
            ready_in_bus[p] = ready_en & ~full[p];
            push[p]         = valid_in_bus[p] & ready_in_bus[p];
            head_flit[p]    = mem[p][rd_ptr[p][AW-1:0]];
            route[p]        = route_of(head_flit[p][DATA_WIDTH-3 -: DEST_WIDTH]);
        end
    end

    // Grant is combinational in IDLE so a head flit leaves the cycle after it is written.
    always_comb begin
        hit           = '0;
        active        = '0;
        xfer          = '0;
        pop           = '0;
        valid_out_bus = '0;
        data_out_bus  = '0;
        for (int o = 0; o < 3; o++) begin
            req[o]     = '0;
            gnt[o]     = rr_q[o];
            state_d[o] = state_q[o];
            src_d[o]   = src_q[o];
            rr_d[o]    = rr_q[o];
            for (int i = 0; i < 3; i++) begin
                req[o][i] = ~empty[i] & head_flit[i][DATA_WIDTH-2] & (route[i] == 2'(o));
            end
            for (int k = 2; k >= 0; k--) begin
                if (req[o][wrap3(rr_q[o], k)]) begin
                    hit[o] = 1'b1;
                    gnt[o] = wrap3(rr_q[o], k);
                end
            end
            active[o]        = (state_q[o] == LOCKED) | hit[o];
            sel[o]           = (state_q[o] == LOCKED) ? src_q[o] : gnt[o];
            valid_out_bus[o] = active[o] & ~empty[sel[o]];
            xfer[o]          = valid_out_bus[o] & ready_out_bus[o];
            if (valid_out_bus[o]) data_out_bus[o*DATA_WIDTH +: DATA_WIDTH] = head_flit[sel[o]];
            if (state_q[o] == IDLE && hit[o]) begin
                state_d[o] = LOCKED;
                src_d[o]   = gnt[o];
            end
            if (xfer[o] && head_flit[sel[o]][DATA_WIDTH-1]) begin
                state_d[o] = IDLE;
                rr_d[o]    = wrap3(sel[o], 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int o = 0; o < 3; o++) begin
                if (xfer[o] && sel[o] == 2'(i)) pop[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < 3; o++) begin
                state_q[o] <= IDLE;
                src_q[o]   <= '0;
                rr_q[o]    <= '0;
            end
        end else begin
            for (int o = 0; o < 3; o++) begin
                state_q[o] <= state_d[o];
                src_q[o]   <= src_d[o];
                rr_q[o]    <= rr_d[o];
            end
        end
    end

`ifdef LINEAR_ROUTER_STATS_EN
    logic [31:0] cnt_q [3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < 3; o++) cnt_q[o] <= '0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (xfer[o] && cnt_q[o] != '1) cnt_q[o] <= cnt_q[o] + 32'd1;
            end
        end
    end

    always_comb begin
        flit_count = '0;
        for (int o = 0; o < 3; o++) flit_count[o*32 +: 32] = cnt_q[o];
    end
`endif

endmodule

// File: tb/tb_linear_router.sv
// Scoreboard bench for linear_router: node INDEX=1 (dut) and node INDEX=0 (dut0), both N=4, depth 4.
module tb_linear_router;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3*DW-1:0] din_bus_a, din_bus_b, dout_a, dout_b;
    logic [2:0]      vin_bus_a, vin_bus_b, rin_a, rin_b, vout_a, vout_b, rout_a, rout_b;
    logic [DW-1:0]   din [2][3];
    logic            vin [2][3];
`ifdef LINEAR_ROUTER_STATS_EN
    logic [95:0]     cnt_a, cnt_b;
`endif

    always_comb begin
        din_bus_a = '0;
        din_bus_b = '0;
        vin_bus_a = '0;
        vin_bus_b = '0;
        for (int p = 0; p < 3; p++) begin
            din_bus_a[p*DW +: DW] = din[0][p];
            din_bus_b[p*DW +: DW] = din[1][p];
            vin_bus_a[p]          = vin[0][p];
            vin_bus_b[p]          = vin[1][p];
        end
    end

    linear_router #(.N(4), .INDEX(1), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .data_in_bus(din_bus_a), .valid_in_bus(vin_bus_a), .ready_in_bus(rin_a),
        .data_out_bus(dout_a), .valid_out_bus(vout_a),
`ifdef LINEAR_ROUTER_STATS_EN
        .flit_count(cnt_a),
`endif
        .ready_out_bus(rout_a)
    );

    linear_router #(.N(4), .INDEX(0), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst),
        .data_in_bus(din_bus_b), .valid_in_bus(vin_bus_b), .ready_in_bus(rin_b),
        .data_out_bus(dout_b), .valid_out_bus(vout_b),
`ifdef LINEAR_ROUTER_STATS_EN
        .flit_count(cnt_b),
`endif
        .ready_out_bus(rout_b)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q [6][$];

    // Flit layout: type[15:14] dest[13:12] tag[11:4] index[3:0]; non-head flits carry a bogus dest.
    function automatic logic [DW-1:0] pkt_flit(input int dest, input int len, input int k, input int tag);
        logic [1:0] ty;
        logic [1:0] d;
        logic [7:0] t;
        logic [3:0] kk;
        if (len == 1)         ty = 2'b11;
        else if (k == 0)      ty = 2'b01;
        else if (k == len-1)  ty = 2'b10;
        else                  ty = 2'b00;
        d  = (ty[0]) ? dest[1:0] : ~dest[1:0];
        t  = tag[7:0];
        kk = k[3:0];
        return {ty, d, t, kk};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input int inst, input int p, input logic [DW-1:0] f);
        int   budget;
        logic r;
        budget = 0;
        din[inst][p] = f;
        vin[inst][p] = 1'b1;
        forever begin
            @(negedge clk);
            r = (inst == 0) ? rin_a[p] : rin_b[p];
            @(posedge clk);
            if (r) break;
            budget++;
            if (budget > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout inst%0d port%0d actual=not_accepted required=accepted", inst, p);
                break;
            end
        end
        #1;
        vin[inst][p] = 1'b0;
    endtask

    task automatic send_pkt(input int inst, input int p, input int dest, input int len, input int tag);
        for (int k = 0; k < len; k++) send(inst, p, pkt_flit(dest, len, k, tag));
    endtask

    task automatic expect_pkt(input int inst, input int o, input int dest, input int len, input int tag);
        for (int k = 0; k < len; k++) exp_q[inst*3+o].push_back(pkt_flit(dest, len, k, tag));
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int k = 0; k < 6; k++) s += exp_q[k].size();
        return s;
    endfunction

    task automatic wait_drain(input string name);
        for (int c = 0; c < 200 && pending() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        chk(name, 64'(pending()), 64'd0);
    endtask

    logic          mon_valid, mon_ready;
    logic [DW-1:0] mon_data, mon_exp;

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 6; k++) begin
                mon_valid = (k < 3) ? vout_a[k%3] : vout_b[k%3];
                mon_ready = (k < 3) ? rout_a[k%3] : rout_b[k%3];
                mon_data  = (k < 3) ? dout_a[(k%3)*DW +: DW] : dout_b[(k%3)*DW +: DW];
                if (mon_valid && mon_ready) begin
                    n_chk++;
                    if (exp_q[k].size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected inst%0d port%0d actual=%h required=none", k/3, k%3, mon_data);
                    end else begin
                        mon_exp = exp_q[k].pop_front();
                        if (mon_data !== mon_exp) begin
                            n_fail++;
                            $display("FAIL sb_data inst%0d port%0d actual=%h required=%h", k/3, k%3, mon_data, mon_exp);
                        end
                    end
                end
            end
        end
    end

    logic pkt_done;

    initial begin
        rst    = 1'b0;
        rout_a = 3'b111;
        rout_b = 3'b111;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 3; p++) begin
                din[i][p] = '0;
                vin[i][p] = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_in", 64'(rin_a), 64'd0);
        chk("rst_valid_out", 64'(vout_a), 64'd0);
        chk("rst_data_out", 64'(dout_a), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_before_first_edge", 64'(rin_a), 64'd0);
        @(posedge clk);
        #1;
        chk("ready_after_release", 64'(rin_a), 64'h7);

        // Two 3-flit packets to dest 0 race for the west output; input 0 wins first.
        expect_pkt(0, 1, 0, 3, 'h30);
        expect_pkt(0, 1, 0, 3, 'h32);
        fork
            send_pkt(0, 0, 0, 3, 'h30);
            send_pkt(0, 2, 0, 3, 'h32);
        join
        wait_drain("drain_contention");

        // Single flit east with one-cycle latency.
        expect_pkt(0, 2, 3, 1, 'h37);
        send(0, 0, pkt_flit(3, 1, 0, 'h37));
        chk("latency_valid", 64'(vout_a[2]), 64'd1);
        chk("latency_data", 64'(dout_a[2*DW +: DW]), 64'(pkt_flit(3, 1, 0, 'h37)));
        wait_drain("drain_single");

        // 6-flit local packet under a toggling output ready.
        expect_pkt(0, 0, 1, 6, 'h38);
        pkt_done = 1'b0;
        fork
            begin
                send_pkt(0, 1, 1, 6, 'h38);
                pkt_done = 1'b1;
            end
            begin
                for (int c = 0; c < 100 && !pkt_done; c++) begin
                    rout_a[0] = ~rout_a[0];
                    @(posedge clk);
                    #1;
                end
            end
        join
        rout_a[0] = 1'b1;
        wait_drain("drain_toggle");
        chk("idle_after_toggle", 64'(vout_a[0]), 64'd0);

        // Back-pressure: 4 flits fill the FIFO, the 5th waits for a pop.
        rout_a[2] = 1'b0;
        for (int k = 0; k < 5; k++) expect_pkt(0, 2, 3, 1, 'h40 + k);
        for (int k = 0; k < 4; k++) send(0, 0, pkt_flit(3, 1, 0, 'h40 + k));
        chk("full_ready_low", 64'(rin_a[0]), 64'd0);
        pkt_done = 1'b0;
        fork
            begin
                send(0, 0, pkt_flit(3, 1, 0, 'h44));
                pkt_done = 1'b1;
            end
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("fifth_held_ready", 64'(rin_a[0]), 64'd0);
        chk("fifth_held_pending", 64'(pkt_done), 64'd0);
        chk("held_valid", 64'(vout_a[2]), 64'd1);
        chk("held_data", 64'(dout_a[2*DW +: DW]), 64'(pkt_flit(3, 1, 0, 'h40)));
        rout_a[2] = 1'b1;
        for (int c = 0; c < 50 && !pkt_done; c++) begin
            @(posedge clk);
            #1;
        end
        wait_drain("drain_backpressure");

        // Reset after 2 of 4 flits have left; the rest must never appear.
        rout_a[0] = 1'b0;
        for (int k = 0; k < 4; k++) send(0, 0, pkt_flit(1, 4, k, 'h41));
        exp_q[0].push_back(pkt_flit(1, 4, 0, 'h41));
        exp_q[0].push_back(pkt_flit(1, 4, 1, 'h41));
        rout_a[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(vout_a), 64'd0);
        chk("async_rst_data", 64'(dout_a), 64'd0);
        chk("async_rst_ready", 64'(rin_a), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_valid", 64'(vout_a), 64'd0);
        chk("post_rst_ready", 64'(rin_a), 64'h7);
        chk("post_rst_two_left", 64'(pending()), 64'd0);

        // INDEX 0 node: head to dest 0 arriving from the east goes local.
        expect_pkt(1, 0, 0, 2, 'h42);
        send_pkt(1, 2, 0, 2, 'h42);
        wait_drain("drain_index0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/linear_router.md
LINEAR_ROUTER -- requirements
Module: linear_router

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of nodes in the linear chain.
REQ-002 The block SHALL have parameter INDEX, default 0, meaning this node's position in the chain (0..N-1).
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning the flit width in bits.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16, meaning the per-input buffer depth in flits (power of two, at least 2).
REQ-005 The block SHALL have parameter DEST_WIDTH, default $clog2(N), meaning the width of the destination field.
REQ-006 The block SHALL have port clk, input, width 1, the single clock; all logic SHALL be clocked on its rising edge.
REQ-007 The block SHALL have port rst, input, width 1, an asynchronous active-low reset.
REQ-008 The block SHALL have port data_in_bus, input, width 3*DATA_WIDTH, carrying input flits; slice p belongs to port p (0 local, 1 west, 2 east).
REQ-009 The block SHALL have port valid_in_bus, input, width 3, the per-input-port valid signals.
REQ-010 The block SHALL have port ready_in_bus, output, width 3, the per-input-port ready signals.
REQ-011 The block SHALL have port data_out_bus, output, width 3*DATA_WIDTH, carrying output flits with the same port order as the inputs.
REQ-012 The block SHALL have port valid_out_bus, output, width 3, the per-output-port valid signals.
REQ-013 The block SHALL have port ready_out_bus, input, width 3, the per-output-port ready signals.

Function
REQ-014 The flit type field SHALL be data[DATA_WIDTH-1:DATA_WIDTH-2], encoded as: 01 head, 00 body, 10 tail, 11 single (head plus tail).
REQ-015 The destination field SHALL be data[DATA_WIDTH-3 -: DEST_WIDTH] and SHALL be valid only in head and single flits.
REQ-016 A transfer SHALL occur on any port in a cycle where valid and ready are both high; valid, once asserted, SHALL hold with stable data until that transfer.
REQ-017 Each input port SHALL have a FIFO of FIFO_DEPTH entries, and ready_in_bus[p] SHALL be high exactly when FIFO p is not full.
REQ-018 A simultaneous push and pop on a full FIFO SHALL NOT be accepted; ready reflects the registered full state only.
REQ-019 Routing SHALL use the head destination: dest==INDEX goes to port 0, dest<INDEX goes to port 1, dest>INDEX goes to port 2, and dest>=N goes to port 0.
REQ-020 At INDEX 0 a west-routed head SHALL instead go to port 0, and at INDEX N-1 an east-routed head SHALL instead go to port 0.
REQ-021 Each output SHALL have a two-state FSM, IDLE and LOCKED.
REQ-022 In IDLE, the output SHALL grant round-robin among inputs whose FIFO head is a head or single flit routed to it, starting the search at input rr_ptr.
REQ-023 On grant, the FSM SHALL move IDLE to LOCKED, and SHALL move LOCKED to IDLE after the tail (or single) flit transfers out.
REQ-024 After each packet completes, rr_ptr SHALL be set to the granted input + 1, mod 3.
REQ-025 A single flit SHALL forward the flit and return to IDLE in the same cycle.
REQ-026 While an output is LOCKED, its input's body and tail flits SHALL forward in order, with no interleaving from other inputs.
REQ-027 valid_out SHALL be the locked input's FIFO non-empty signal, and data_out SHALL be that FIFO's head flit.
REQ-028 Minimum latency SHALL be one cycle: a flit accepted at edge t SHALL be visible on the output after edge t.
REQ-029 Sustained throughput SHALL be one flit per cycle per output.
REQ-030 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with full and empty derived from an extra pointer bit.
REQ-031 When two outputs grant in the same cycle, each input SHALL be granted to at most one output, since every head flit routes to exactly one port.

Reset
REQ-032 While rst is low, all FIFOs SHALL be empty, all FSMs SHALL be IDLE, rr_ptr SHALL be 0, valid_out_bus SHALL be 0, data_out_bus SHALL be 0, and ready_in_bus SHALL be 0.
REQ-033 ready_in_bus SHALL become 3'b111 on the first rising edge after rst is released.
REQ-034 Assertion of rst in the middle of a packet SHALL discard all buffered flits and lock state immediately, with no partial packet emitted after release.

Configuration
REQ-035 With LINEAR_ROUTER_STATS_EN defined, the block SHALL add output port flit_count, width 3*32, as per-output saturating counters of transferred flits, reset to 0.
REQ-036 Without LINEAR_ROUTER_STATS_EN, the flit_count port and the counter logic SHALL be absent, and the behaviour shall be otherwise identical.

Verification
REQ-037 Scenario: INDEX=1, N=4, single flit dest=3 on port 0 -> the flit appears on port 2 one cycle later, unchanged.
REQ-038 Scenario: a 6-flit packet on port 1 to dest 1 with ready_out[0] toggling every cycle -> all 6 flits arrive on port 0 in order and the FSM returns to IDLE.
REQ-039 Scenario: ports 0 and 2 both send 3-flit packets to dest 0 at INDEX 1 -> port 1 carries two contiguous packets (input 0 first), with no interleaving.
REQ-040 Scenario: FIFO_DEPTH=4 with ready_out held low and 5 flits offered -> ready_in drops after the 4th flit, and the 5th is held until a pop.
REQ-041 Scenario: rst driven low after 2 of 4 flits have left -> outputs go to 0 asynchronously, and after release no remaining flit of that packet appears.
REQ-042 Scenario: INDEX=0, head with dest=0 arriving on port 2 -> the flit is delivered on port 0.
